sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO with valid/ready handshakes on both sides, first-word-fall-through read, occupancy count, almost-full/almost-empty flags, synchronous flush and a peak-occupancy monitor. It is the general buffering block for AXI channel staging inside one clock domain, such as the AW/W/B/AR/R skid and decoupling buffers between master ports and the interconnect. Storage is a flop-based RAM written on the clock edge and read combinationally at the read pointer.

---
 rtl/sync_fifo_param.sv | 111 +++++++++++
 tb/tb_sync_fifo_param.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with valid/ready on both sides,
// first-word-fall-through read, occupancy count, almost flags, synchronous
// flush and a peak-occupancy monitor.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   max_level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] max_level_q, max_level_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status decodes come only from registered pointers/count, so the
  // handshake outputs never depend combinationally on the opposite side.
  always_comb begin
    empty        = (wptr_q == rptr_q);
    full         = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    in_ready     = !full;
    out_valid    = !empty;
    push         = in_valid && !full;
    pop          = out_ready && !empty;
    count        = count_q;
    max_level    = max_level_q;
    almost_full  = (count_q >= AFULL_T);
    almost_empty = (count_q <= AEMPTY_T);
    out_data     = mem[rptr_q[ADDR_WIDTH-1:0]];
  end

  // Next-state for pointers, occupancy and peak; flush discards any
  // same-cycle push/pop.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    max_level_d = max_level_q;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      max_level_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + PW'(1);
      end else if (pop && !push) begin
        count_d = count_q - PW'(1);
      end
      if (count_d > max_level_q) begin
        max_level_d = count_d;
      end
    end
  end

  // Control state register; reset outranks flush, which outranks traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      max_level_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      max_level_q <= max_level_d;
    end
  end

  // Storage write; contents are never cleared, a flushed push is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: accepted words are queued by the
// bench model and compared when they reach the head of the DUT.
module tb_sync_fifo_param;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  max_level;

  int          n_vec;
  int          n_err;
  logic [31:0] mq[$];
  int          mmax;
  logic        last_push;

  sync_fifo_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .max_level(max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check DUT state against the model,
  // advance the model, then cross the rising edge.
  task automatic step(input logic r, input logic fl, input logic vi,
                      input logic [31:0] di, input logic ordy);
    int   sz;
    logic pu;
    logic po;
    rst = r; flush = fl; in_valid = vi; in_data = di; out_ready = ordy;
    #1;
    sz = mq.size();
    chk("in_ready",     32'(in_ready),     32'(sz < 16));
    chk("out_valid",    32'(out_valid),    32'(sz > 0));
    chk("count",        32'(count),        32'(sz));
    chk("almost_full",  32'(almost_full),  32'(sz >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    chk("max_level",    32'(max_level),    32'(mmax));
    if (sz > 0) chk("out_data", out_data, mq[0]);
    pu = vi && (sz < 16);
    po = ordy && (sz > 0);
    if (r || fl) begin
      mq.delete();
      mmax = 0;
      last_push = 1'b0;
      $display("clear rst=%0b flush=%0b", r, fl);
    end else begin
      if (po) begin
        $display("pop  %h", mq[0]);
        void'(mq.pop_front());
      end
      if (pu) mq.push_back(di);
      if (mq.size() > mmax) mmax = mq.size();
      last_push = pu;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; mmax = 0; last_push = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, one idle cycle.
    step(0, 0, 0, 32'h0, 0);

    // Fill with 0xA000..0xA00F, no consumer.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 32'hA000 + 32'(i), 0);
    // Held 17th word is refused while full.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hDEAD, 0);
    chk("full_count", 32'(count), 32'd16);
    // Drain; 0xDEAD stays offered until taken and comes out last.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, in_valid, 32'hDEAD, 1);
      if (last_push) in_valid = 1'b0;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Steady state at 8 entries across pointer wraps.
    step(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'hB000 + 32'(i), 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 32'hB008 + 32'(i), 1);
    step(0, 0, 0, 32'h0, 0);
    chk("steady_max", 32'(max_level), 32'd8);
    chk("steady_cnt", 32'(count), 32'd8);

    // Flush at count 10 with peak 14, while pushing.
    step(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 32'hC000 + 32'(i), 0);
    for (int i = 0; i < 4; i++)  step(0, 0, 0, 32'h0, 1);
    chk("pre_flush_cnt", 32'(count), 32'd10);
    chk("pre_flush_max", 32'(max_level), 32'd14);
    step(0, 1, 1, 32'hF1F1F1F1, 1);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_ov",  32'(out_valid), 32'd0);
    chk("flush_max", 32'(max_level), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hD000 + 32'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);

    // Reset mid-burst.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hE000 + 32'(i), 0);
    step(1, 0, 1, 32'hE0FF, 1);
    chk("rst_cnt", 32'(count), 32'd0);

    // Random traffic with rare flushes.
    for (int i = 0; i < 2000; i++) begin
      step(0, ($urandom_range(99) == 0), 1'($urandom_range(1)), $urandom,
           1'($urandom_range(1)));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 1);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
